avr_sram_bridge: RTL and testbench

//  Parametrised AVR<->SRAM bus bridge; next generation of the fixed 8/21-bit sreg + bus_fsm + counter path.

---
 rtl/avr_sram_bridge.sv | 179 +++++++++++++++++
 tb/tb_avr_sram_bridge.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/avr_sram_bridge.sv
// ============================================================================
// Module      : avr_sram_bridge
// Description : AVR<->SRAM bridge with a serially loaded address, timed SRAM
//               read/write cycles, an address counter and SNES bus hand-over.
//               Optional AVR_SRAM_AUTO_INC_EN: address += 1 after every access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module avr_sram_bridge #(
    parameter int ADDR_W      = 21,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              avr_clk,
    input  logic              avr_reset,
    input  logic              avr_sreg_en_n,
    input  logic              avr_si,
    input  logic              avr_counter_n,
    input  logic              avr_oe_n,
    input  logic              avr_we_n,
    input  logic              avr_snes_mode,
    input  logic [DATA_W-1:0] avr_data_in,
    output logic [DATA_W-1:0] avr_data_out,
    output logic              avr_busy,
    input  logic [ADDR_W-1:0] snes_addr,
    input  logic              snes_oe_n,
    input  logic              snes_we_n,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_data_in,
    output logic [DATA_W-1:0] sram_data_out,
    output logic              sram_data_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam int WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_CYCLES - 1);
`ifdef AVR_SRAM_AUTO_INC_EN
    localparam logic AUTO_INC = 1'b1;
`else
    localparam logic AUTO_INC = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_WAIT  = 3'd1,
        S_RD_LATCH = 3'd2,
        S_WR_SETUP = 3'd3,
        S_WR_PULSE = 3'd4,
        S_WR_HOLD  = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WCNT_W-1:0]   wait_q;
    logic [DATA_W-1:0]   data_out_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                oe_prev_q, we_prev_q, cnt_prev_q;
    logic                ce_n_q, oe_n_q, we_n_q, data_oe_q, busy_q;
    logic                mode_q, pend_q, is_wr_q;

    logic                oe_fall, we_fall, cnt_fall;
    logic [1:0]          inc_amt;

    assign oe_fall  = oe_prev_q  & ~avr_oe_n;
    assign we_fall  = we_prev_q  & ~avr_we_n;
    assign cnt_fall = cnt_prev_q & ~avr_counter_n;
    // Increment applied when leaving DONE: deferred counter edge plus optional auto-increment
    assign inc_amt  = {1'b0, pend_q | cnt_fall} + {1'b0, AUTO_INC};

    always_ff @(posedge avr_clk or posedge avr_reset) begin
        if (avr_reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wait_q     <= '0;
            data_out_q <= '0;
            wr_data_q  <= '0;
            oe_prev_q  <= 1'b1;
            we_prev_q  <= 1'b1;
            cnt_prev_q <= 1'b1;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            data_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            mode_q     <= 1'b0;
            pend_q     <= 1'b0;
            is_wr_q    <= 1'b0;
        end else begin
            oe_prev_q  <= avr_oe_n;
            we_prev_q  <= avr_we_n;
            cnt_prev_q <= avr_counter_n;
            if (state_q != S_IDLE && cnt_fall)
                pend_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    mode_q <= avr_snes_mode;
                    if (!mode_q) begin
                        if (!avr_sreg_en_n)
                            addr_q <= {addr_q[ADDR_W-2:0], avr_si};
                        else if (cnt_fall)
                            addr_q <= addr_q + 1'b1;
                        // Simultaneous strobes: the write is taken, the read is dropped
                        if (we_fall) begin
                            state_q   <= S_WR_SETUP;
                            is_wr_q   <= 1'b1;
                            wr_data_q <= avr_data_in;
                            ce_n_q    <= 1'b0;
                            data_oe_q <= 1'b1;
                            busy_q    <= 1'b1;
                        end else if (oe_fall) begin
                            state_q <= S_RD_WAIT;
                            is_wr_q <= 1'b0;
                            ce_n_q  <= 1'b0;
                            oe_n_q  <= 1'b0;
                            busy_q  <= 1'b1;
                            wait_q  <= '0;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (wait_q == WAIT_LAST)
                        state_q <= S_RD_LATCH;
                    else
                        wait_q <= wait_q + 1'b1;
                end
                S_RD_LATCH: begin
                    data_out_q <= sram_data_in;
                    ce_n_q     <= 1'b1;
                    oe_n_q     <= 1'b1;
                    state_q    <= S_DONE;
                end
                S_WR_SETUP: begin
                    we_n_q  <= 1'b0;
                    wait_q  <= '0;
                    state_q <= S_WR_PULSE;
                end
                S_WR_PULSE: begin
                    if (wait_q == WAIT_LAST) begin
                        we_n_q  <= 1'b1;
                        state_q <= S_WR_HOLD;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_WR_HOLD: begin
                    ce_n_q    <= 1'b1;
                    data_oe_q <= 1'b0;
                    state_q   <= S_DONE;
                end
                S_DONE: begin
                    if (is_wr_q ? avr_we_n : avr_oe_n) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        pend_q  <= 1'b0;
                        addr_q  <= addr_q + {{(ADDR_W-2){1'b0}}, inc_amt};
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign avr_data_out  = data_out_q;
    assign avr_busy      = busy_q;
    assign sram_data_out = wr_data_q;
    assign sram_addr     = mode_q ? snes_addr                : addr_q;
    assign sram_oe_n     = mode_q ? snes_oe_n                : oe_n_q;
    assign sram_we_n     = mode_q ? snes_we_n                : we_n_q;
    assign sram_ce_n     = mode_q ? (snes_oe_n & snes_we_n)  : ce_n_q;
    assign sram_data_oe  = mode_q ? 1'b0                     : data_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_avr_sram_bridge.sv
// ============================================================================
// Module      : tb_avr_sram_bridge
// Description : Directed self-checking bench for avr_sram_bridge (default build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_avr_sram_bridge;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              sreg_en_n, si, counter_n, oe_n, we_n, snes_mode;
    logic [DATA_W-1:0] data_in, data_out, sram_din, sram_dout;
    logic              busy;
    logic [ADDR_W-1:0] snes_addr, sram_addr;
    logic              snes_oe_n, snes_we_n;
    logic              data_oe, ce_n_o, oe_n_o, we_n_o;

    int total = 0;
    int bad   = 0;

    avr_sram_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(2)) dut (
        .avr_clk       (clk),
        .avr_reset     (rst),
        .avr_sreg_en_n (sreg_en_n),
        .avr_si        (si),
        .avr_counter_n (counter_n),
        .avr_oe_n      (oe_n),
        .avr_we_n      (we_n),
        .avr_snes_mode (snes_mode),
        .avr_data_in   (data_in),
        .avr_data_out  (data_out),
        .avr_busy      (busy),
        .snes_addr     (snes_addr),
        .snes_oe_n     (snes_oe_n),
        .snes_we_n     (snes_we_n),
        .sram_addr     (sram_addr),
        .sram_data_in  (sram_din),
        .sram_data_out (sram_dout),
        .sram_data_oe  (data_oe),
        .sram_ce_n     (ce_n_o),
        .sram_oe_n     (oe_n_o),
        .sram_we_n     (we_n_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] pat;
        pat = 16'h4ccf;
        rst = 1'b1; sreg_en_n = 1'b1; si = 1'b0; counter_n = 1'b1;
        oe_n = 1'b1; we_n = 1'b1; snes_mode = 1'b0; data_in = '0;
        snes_addr = '0; snes_oe_n = 1'b1; snes_we_n = 1'b1; sram_din = '0;
        tick(); tick();
        chk("rst_ce", 32'(ce_n_o), 1);
        chk("rst_oe", 32'(oe_n_o), 1);
        chk("rst_we", 32'(we_n_o), 1);
        chk("rst_doe", 32'(data_oe), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", 32'(sram_addr), 0);
        rst = 1'b0;
        tick();

        // Shift 0x4ccf MSB-first
        for (int i = 15; i >= 0; i--) begin
            sreg_en_n = 1'b0; si = pat[i];
            tick();
        end
        sreg_en_n = 1'b1;
        tick();
        chk("shift_addr", 32'(sram_addr), 32'h4ccf);

        // Read with a counter edge while busy
        sram_din = 8'haa; oe_n = 1'b0;
        tick();
        chk("rd_oe_p1", 32'(oe_n_o), 0);
        chk("rd_busy", 32'(busy), 1);
        counter_n = 1'b0;
        tick();
        counter_n = 1'b1;
        chk("rd_we_p2", 32'(we_n_o), 1);
        tick();
        chk("rd_oe_p3", 32'(oe_n_o), 0);
        chk("rd_data_early", 32'(data_out), 0);
        tick();
        chk("rd_data", 32'(data_out), 32'haa);
        chk("rd_oe_p4", 32'(oe_n_o), 1);
        chk("rd_addr_hold", 32'(sram_addr), 32'h4ccf);
        oe_n = 1'b1;
        tick();
        chk("rd_idle", 32'(busy), 0);
        chk("pend_inc", 32'(sram_addr), 32'h4cd0);

        // Write
        data_in = 8'hee; we_n = 1'b0;
        tick();
        chk("wr_setup_doe", 32'(data_oe), 1);
        chk("wr_setup_we", 32'(we_n_o), 1);
        chk("wr_dout", 32'(sram_dout), 32'hee);
        tick();
        chk("wr_pulse1", 32'(we_n_o), 0);
        chk("wr_pulse_oe", 32'(oe_n_o), 1);
        tick();
        chk("wr_pulse2", 32'(we_n_o), 0);
        tick();
        chk("wr_hold_we", 32'(we_n_o), 1);
        chk("wr_hold_doe", 32'(data_oe), 1);
        tick();
        chk("wr_done_doe", 32'(data_oe), 0);
        we_n = 1'b1;
        tick();
        chk("wr_idle", 32'(busy), 0);

        // Counter wrap at 0x1fffff
        for (int i = 0; i < ADDR_W; i++) begin
            sreg_en_n = 1'b0; si = 1'b1;
            tick();
        end
        sreg_en_n = 1'b1;
        tick();
        chk("all_ones", 32'(sram_addr), 32'h1fffff);
        counter_n = 1'b0;
        tick();
        counter_n = 1'b1;
        chk("wrap", 32'(sram_addr), 0);

        // Simultaneous read and write strobes: write wins
        oe_n = 1'b0; we_n = 1'b0;
        tick();
        chk("both_doe", 32'(data_oe), 1);
        chk("both_oe", 32'(oe_n_o), 1);
        tick(); tick(); tick(); tick();
        oe_n = 1'b1; we_n = 1'b1;
        tick();
        chk("both_idle", 32'(busy), 0);

        // Shift and increment in the same cycle: shift wins
        sreg_en_n = 1'b0; si = 1'b1; counter_n = 1'b0;
        tick();
        sreg_en_n = 1'b1; counter_n = 1'b1;
        chk("shift_wins", 32'(sram_addr), 1);

        // SNES mode requested mid-read
        sram_din = 8'h5a; oe_n = 1'b0;
        tick();
        snes_mode = 1'b1; snes_addr = 21'h123456; snes_oe_n = 1'b0; snes_we_n = 1'b1;
        tick();
        chk("snes_defer_addr", 32'(sram_addr), 1);
        chk("snes_defer_oe", 32'(oe_n_o), 0);
        tick(); tick();
        chk("snes_rd_data", 32'(data_out), 32'h5a);
        oe_n = 1'b1;
        tick();
        chk("snes_idle_addr", 32'(sram_addr), 1);
        tick();
        chk("snes_addr", 32'(sram_addr), 32'h123456);
        chk("snes_oe", 32'(oe_n_o), 0);
        chk("snes_ce", 32'(ce_n_o), 0);
        chk("snes_doe", 32'(data_oe), 0);
        we_n = 1'b0;
        tick();
        chk("snes_ignore_we", 32'(busy), 0);
        we_n = 1'b1; snes_mode = 1'b0;
        tick();
        chk("avr_back", 32'(sram_addr), 1);

        // Async reset during the write pulse
        data_in = 8'h3c; we_n = 1'b0;
        tick(); tick();
        chk("pre_rst_we", 32'(we_n_o), 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_we", 32'(we_n_o), 1);
        chk("rst_mid_doe", 32'(data_oe), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_addr", 32'(sram_addr), 0);
        we_n = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
